// File: rtl/pa_clkrst_seq.sv
// Multi-domain clock/reset sequencer: staggered reset release, low-power clock
// gating handshake, and soft-reset re-sequencing, all on the free-running core clock.
module pa_clkrst_seq #(
    parameter int CH_NUM    = 4,
    parameter int CNT_W     = 8,
    parameter int STAGE_DLY = 16
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst,
    input  logic              soft_rst_req,
    input  logic              lp_req,
    input  logic [CH_NUM-1:0] ch_idle,
    output logic [CH_NUM-1:0] ch_rst_b,
    output logic [CH_NUM-1:0] ch_clk_en,
    output logic              lp_ack,
    output logic              seq_done,
    output logic [2:0]        dbg_state
);

    localparam int                IDX_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [CNT_W-1:0]  DLY_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(CH_NUM - 1);
    localparam logic [CH_NUM-1:0] ALL_ON   = '1;

    typedef enum logic [2:0] {
        S_RELEASE = 3'd0,
        S_RUN     = 3'd1,
        S_GATE    = 3'd2,
        S_SLEEP   = 3'd3,
        S_UNGATE  = 3'd4
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic [CH_NUM-1:0] gate_clr_mask;
    logic [CH_NUM-1:0] ungate_set_mask;
    logic [CH_NUM-1:0] gate_next;
    logic [CH_NUM-1:0] ungate_next;

    assign dbg_state = state;

    // Enables stay a contiguous run of ones from bit 0: gating removes the
    // highest enabled domain, ungating restores the lowest gated one.
    always_comb begin
        gate_clr_mask   = '0;
        ungate_set_mask = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (ch_clk_en[i]) gate_clr_mask = CH_NUM'(1) << i;
        end
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (!ch_clk_en[i]) ungate_set_mask = CH_NUM'(1) << i;
        end
        gate_next   = ch_clk_en & ~gate_clr_mask;
        ungate_next = ch_clk_en | ungate_set_mask;
    end

    // lp_req/lp_ack form a four-phase level handshake: lp_ack rises only after
    // lp_req is held through full gating, and falls on the edge lp_req is seen low.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state     <= S_RELEASE;
            idx       <= '0;
            cnt       <= '0;
            ch_rst_b  <= '0;
            ch_clk_en <= ALL_ON;
            lp_ack    <= 1'b0;
            seq_done  <= 1'b0;
        end else begin
            case (state)
                S_RELEASE: begin
                    seq_done <= 1'b0;
                    if (cnt == DLY_LAST) begin
                        cnt           <= '0;
                        ch_rst_b[idx] <= 1'b1;
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            state <= S_RUN;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (soft_rst_req) begin
                        ch_rst_b <= '0;
                        idx      <= '0;
                        cnt      <= '0;
                        seq_done <= 1'b0;
                        state    <= S_RELEASE;
                    end else if (lp_req) begin
                        seq_done <= 1'b0;
                        state    <= S_GATE;
                    end else begin
                        seq_done <= 1'b1;
                    end
                end
                S_GATE: begin
                    seq_done <= 1'b0;
                    if (!lp_req) begin
                        state <= (ch_clk_en == ALL_ON) ? S_RUN : S_UNGATE;
                    end else if (ch_clk_en != ALL_ON || ch_idle == ALL_ON) begin
                        // Once gating has begun it completes without re-checking idle.
                        ch_clk_en <= gate_next;
                        if (gate_next == '0) begin
                            lp_ack <= 1'b1;
                            state  <= S_SLEEP;
                        end
                    end
                end
                S_SLEEP: begin
                    if (!lp_req) begin
                        lp_ack <= 1'b0;
                        state  <= S_UNGATE;
                    end
                end
                S_UNGATE: begin
                    ch_clk_en <= ungate_next;
                    if (ungate_next == ALL_ON) state <= S_RUN;
                end
                default: begin
                    state <= S_RELEASE;
                end
            endcase
        end
    end

endmodule
